// File: rtl/cache_mem_arbiter.sv
// Shares one line-wide memory port between icache and dcache.
// Dcache wins by default; a bounded streak lets a waiting icache in.
module cache_mem_arbiter #(
    parameter int LINE_WIDTH   = 256,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_pmem_read,
    input  logic [31:0]           i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,
    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [31:0]           d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [31:0]           pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp,
    output logic                  arb_busy
);
    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    typedef enum logic [1:0] {
        IDLE,
        I_BUSY,
        D_BUSY,
        TURN
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [SW-1:0]         r_streak;
    logic [SW-1:0]         w_streak_nxt;
    logic [31:0]           r_addr;
    logic [31:0]           w_addr_nxt;
    logic                  r_we;
    logic                  w_we_nxt;
    logic [LINE_WIDTH-1:0] r_wdata;
    logic [LINE_WIDTH-1:0] w_wdata_nxt;
    logic                  w_d_req;
    logic                  w_i_starved;
    logic                  w_busy;

    assign w_d_req     = d_pmem_read | d_pmem_write;
    assign w_i_starved = i_pmem_read && (r_streak == STREAK_MAX);
    assign w_busy      = (r_state == I_BUSY) || (r_state == D_BUSY);

    always_comb begin
        w_state_nxt  = r_state;
        w_streak_nxt = r_streak;
        w_addr_nxt   = r_addr;
        w_we_nxt     = r_we;
        w_wdata_nxt  = r_wdata;
        unique case (r_state)
            IDLE: begin
                if (w_d_req && !w_i_starved) begin
                    w_state_nxt = D_BUSY;
                    w_addr_nxt  = d_pmem_address;
                    // a write beats a read if both are (illegally) raised
                    w_we_nxt    = d_pmem_write;
                    w_wdata_nxt = d_pmem_wdata;
                    if (!i_pmem_read) begin
                        w_streak_nxt = '0;
                    end else if (r_streak != STREAK_MAX) begin
                        w_streak_nxt = r_streak + 1'b1;
                    end
                end else if (i_pmem_read) begin
                    w_state_nxt  = I_BUSY;
                    w_addr_nxt   = i_pmem_address;
                    w_we_nxt     = 1'b0;
                    w_wdata_nxt  = '0;
                    w_streak_nxt = '0;
                end
            end
            I_BUSY, D_BUSY: begin
                if (pmem_resp) begin
                    w_state_nxt = TURN;
                end
            end
            TURN: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_streak <= '0;
            r_addr   <= '0;
            r_we     <= 1'b0;
            r_wdata  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_streak <= w_streak_nxt;
            r_addr   <= w_addr_nxt;
            r_we     <= w_we_nxt;
            r_wdata  <= w_wdata_nxt;
        end
    end

    assign pmem_read    = w_busy && !r_we;
    assign pmem_write   = w_busy && r_we;
    assign pmem_address = r_addr;
    assign pmem_wdata   = r_wdata;
    assign arb_busy     = (r_state != IDLE);
    assign i_pmem_resp  = (r_state == I_BUSY) && pmem_resp;
    assign d_pmem_resp  = (r_state == D_BUSY) && pmem_resp;
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

    a_d_onehot : assert property (
        @(posedge clk) disable iff (rst) !(d_pmem_read && d_pmem_write)
    ) else $error("dcache raised read and write together");

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios plus random traffic,
// all checked every cycle against a transaction-level model.
module tb_cache_mem_arbiter;
    localparam int LW   = 256;
    localparam int MAXS = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_pmem_read = 1'b0;
    logic [31:0]   i_pmem_address = '0;
    logic [LW-1:0] i_pmem_rdata;
    logic          i_pmem_resp;
    logic          d_pmem_read = 1'b0;
    logic          d_pmem_write = 1'b0;
    logic [31:0]   d_pmem_address = '0;
    logic [LW-1:0] d_pmem_wdata = '0;
    logic [LW-1:0] d_pmem_rdata;
    logic          d_pmem_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [31:0]   pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata = '0;
    logic          pmem_resp = 1'b0;
    logic          arb_busy;

    cache_mem_arbiter #(.LINE_WIDTH(LW), .MAX_D_STREAK(MAXS)) dut (
        .clk(clk), .rst(rst),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .arb_busy(arb_busy)
    );

    always #5 clk = ~clk;

    int n_tot = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [LW-1:0] got,
                       input logic [LW-1:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom();
        return v;
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // memory model: fixed or random latency, optional stray responses
    int mem_lat  = 0;
    bit mem_off  = 1'b0;
    bit stray_en = 1'b0;
    int m_cnt    = -1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mem_off) begin
                m_cnt = -1;
            end else begin
                pmem_resp  = 1'b0;
                pmem_rdata = rand_line();
                if (pmem_read || pmem_write) begin
                    if (m_cnt < 0)
                        m_cnt = (mem_lat >= 0) ? mem_lat : $urandom_range(0, 5);
                    if (m_cnt == 0) begin
                        pmem_resp = 1'b1;
                        m_cnt = -1;
                    end else begin
                        m_cnt--;
                    end
                end else begin
                    m_cnt = -1;
                    if (stray_en && $urandom_range(0, 9) == 0) pmem_resp = 1'b1;
                end
            end
        end
    end

    // reference model: who owns the port, dead cycle, D grant run length
    int            m_srv = 0;
    bit            m_gap = 1'b0;
    int            m_run = 0;
    logic [31:0]   m_addr = '0;
    bit            m_we = 1'b0;
    logic [LW-1:0] m_wd = '0;
    bit            e_cmd;

    int            rise_cyc[$];
    logic [31:0]   rise_addr[$];
    bit            rise_we[$];
    logic [LW-1:0] rise_wd[$];
    int            resp_cyc[$];
    int            i_cnt = 0;
    int            d_cnt = 0;
    bit            i_seen = 1'b0;
    bit            d_seen = 1'b0;
    bit            prev_cmd = 1'b0;
    bit            busy_at[int];

    always @(negedge clk) begin
        if (rst) begin
            m_srv = 0;
            m_gap = 1'b0;
            m_run = 0;
            chk("rst_rd", pmem_read, 0);
            chk("rst_wr", pmem_write, 0);
            chk("rst_addr", pmem_address, 0);
            chk("rst_wdata", pmem_wdata, 0);
            chk("rst_busy", arb_busy, 0);
            chk("rst_iresp", i_pmem_resp, 0);
            chk("rst_dresp", d_pmem_resp, 0);
        end else begin
            e_cmd = (m_srv != 0);
            chk("pm_rd", pmem_read, e_cmd && !m_we);
            chk("pm_wr", pmem_write, e_cmd && m_we);
            chk("busy", arb_busy, e_cmd || m_gap);
            chk("i_resp", i_pmem_resp, (m_srv == 1) && pmem_resp);
            chk("d_resp", d_pmem_resp, (m_srv == 2) && pmem_resp);
            if (e_cmd) chk("pm_addr", pmem_address, m_addr);
            if (e_cmd && m_we) chk("pm_wdata", pmem_wdata, m_wd);
            chk("i_rdata", i_pmem_rdata, pmem_rdata);
            chk("d_rdata", d_pmem_rdata, pmem_rdata);
            if (m_srv != 0) begin
                if (pmem_resp) begin
                    m_srv = 0;
                    m_gap = 1'b1;
                end
            end else if (m_gap) begin
                m_gap = 1'b0;
            end else if ((d_pmem_read || d_pmem_write) &&
                         !(i_pmem_read && m_run == MAXS)) begin
                m_srv  = 2;
                m_addr = d_pmem_address;
                m_we   = d_pmem_write;
                m_wd   = d_pmem_wdata;
                m_run  = i_pmem_read ? ((m_run < MAXS) ? m_run + 1 : MAXS) : 0;
            end else if (i_pmem_read) begin
                m_srv  = 1;
                m_addr = i_pmem_address;
                m_we   = 1'b0;
                m_run  = 0;
            end
        end
        if ((pmem_read || pmem_write) && !prev_cmd) begin
            rise_cyc.push_back(cyc);
            rise_addr.push_back(pmem_address);
            rise_we.push_back(pmem_write);
            rise_wd.push_back(pmem_wdata);
        end
        prev_cmd = pmem_read || pmem_write;
        if (i_pmem_resp) begin
            i_cnt++;
            i_seen = 1'b1;
            resp_cyc.push_back(cyc);
        end
        if (d_pmem_resp) begin
            d_cnt++;
            d_seen = 1'b1;
            resp_cyc.push_back(cyc);
        end
        busy_at[cyc] = arb_busy;
    end

    task automatic clear_log();
        rise_cyc.delete();
        rise_addr.delete();
        rise_we.delete();
        rise_wd.delete();
        resp_cyc.delete();
        i_cnt = 0;
        d_cnt = 0;
        i_seen = 1'b0;
        d_seen = 1'b0;
    endtask

    task automatic drive();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(input bit is_d, input int lim, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < lim; k++) begin
            @(negedge clk);
            if ((!is_d && i_pmem_resp) || (is_d && d_pmem_resp)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_rise(input int n, input int lim, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < lim; k++) begin
            @(negedge clk);
            if (rise_addr.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    bit            ok;
    int            t0;
    logic [LW-1:0] pat_a5;
    logic [LW-1:0] wd_r;

    initial begin
        pat_a5 = {32{8'hA5}};
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        repeat (2) drive();

        // lone icache read
        clear_log();
        mem_lat = 4;
        drive();
        i_pmem_read = 1'b1;
        i_pmem_address = 32'h0000_0060;
        t0 = cyc;
        wait_resp(1'b0, 20, ok);
        chk("lone_resp_seen", ok, 1);
        drive();
        i_pmem_read = 1'b0;
        repeat (4) drive();
        chk("lone_rises", rise_addr.size(), 1);
        if (rise_addr.size() == 1) begin
            chk("lone_addr", rise_addr[0], 32'h60);
            chk("lone_cmd_cyc", rise_cyc[0], t0 + 1);
            chk("lone_we", rise_we[0], 0);
        end
        chk("lone_icnt", i_cnt, 1);
        chk("lone_dcnt", d_cnt, 0);

        // simultaneous: dcache write first, then icache
        clear_log();
        mem_lat = 2;
        drive();
        i_pmem_read = 1'b1;
        i_pmem_address = 32'h0000_3000;
        d_pmem_write = 1'b1;
        d_pmem_address = 32'h0000_0100;
        d_pmem_wdata = pat_a5;
        wait_resp(1'b1, 20, ok);
        chk("sim_d_seen", ok, 1);
        drive();
        d_pmem_write = 1'b0;
        wait_resp(1'b0, 20, ok);
        chk("sim_i_seen", ok, 1);
        drive();
        i_pmem_read = 1'b0;
        repeat (3) drive();
        chk("sim_rises", rise_addr.size(), 2);
        if (rise_addr.size() == 2 && resp_cyc.size() == 2) begin
            chk("sim_d_addr", rise_addr[0], 32'h100);
            chk("sim_d_we", rise_we[0], 1);
            chk("sim_d_wd", rise_wd[0], pat_a5);
            chk("sim_i_addr", rise_addr[1], 32'h3000);
            chk("sim_i_we", rise_we[1], 0);
            chk("sim_turn_gap", rise_cyc[1] - resp_cyc[0], 3);
        end

        // streak: four D grants, one I grant, then D again
        clear_log();
        mem_lat = 1;
        drive();
        i_pmem_read = 1'b1;
        i_pmem_address = 32'h0000_2000;
        d_pmem_read = 1'b1;
        d_pmem_address = 32'h0000_0100;
        d_pmem_wdata = rand_line();
        for (int k = 0; k < 200 && rise_addr.size() < 6; k++) begin
            drive();
            if (d_seen) begin
                d_seen = 1'b0;
                {d_pmem_read, d_pmem_write} = {d_pmem_write, d_pmem_read};
            end
            if (i_seen) begin
                i_seen = 1'b0;
                i_pmem_read = 1'b0;
            end
        end
        d_pmem_read = 1'b0;
        d_pmem_write = 1'b0;
        i_pmem_read = 1'b0;
        repeat (12) drive();
        chk("streak_enough", rise_addr.size() >= 6, 1);
        if (rise_addr.size() >= 6) begin
            for (int k = 0; k < 4; k++) chk("streak_d", rise_addr[k], 32'h100);
            chk("streak_i", rise_addr[4], 32'h2000);
            chk("streak_d_again", rise_addr[5], 32'h100);
            chk("streak_alt_we", rise_we[1], 1);
            chk("streak_last_we", rise_we[5], 0);
        end

        // address change and withdrawal during D_BUSY
        clear_log();
        mem_lat = 5;
        drive();
        d_pmem_read = 1'b1;
        d_pmem_address = 32'h0000_0400;
        wait_rise(1, 10, ok);
        chk("wd_start", ok, 1);
        drive();
        d_pmem_address = 32'h00BE_EF00;
        d_pmem_read = 1'b0;
        wait_resp(1'b1, 20, ok);
        chk("wd_resp_seen", ok, 1);
        chk("wd_addr_held", pmem_address, 32'h400);
        repeat (4) drive();
        chk("wd_dcnt", d_cnt, 1);
        chk("wd_no_regrant", rise_addr.size(), 1);

        // back-to-back icache reads
        clear_log();
        mem_lat = 2;
        drive();
        i_pmem_read = 1'b1;
        i_pmem_address = 32'h0000_0500;
        wait_resp(1'b0, 20, ok);
        chk("b2b_first", ok, 1);
        drive();
        i_pmem_read = 1'b0;
        drive();
        i_pmem_read = 1'b1;
        i_pmem_address = 32'h0000_0520;
        wait_resp(1'b0, 20, ok);
        chk("b2b_second", ok, 1);
        drive();
        i_pmem_read = 1'b0;
        repeat (3) drive();
        chk("b2b_rises", rise_addr.size(), 2);
        if (rise_addr.size() == 2 && resp_cyc.size() == 2) begin
            t0 = resp_cyc[0];
            chk("b2b_gap", rise_cyc[1] - t0, 3);
            chk("b2b_addr2", rise_addr[1], 32'h520);
            chk("b2b_busy_turn", busy_at[t0 + 1], 1);
            chk("b2b_busy_idle", busy_at[t0 + 2], 0);
            chk("b2b_busy_again", busy_at[t0 + 3], 1);
        end

        // asynchronous reset in D_BUSY, then a stale memory response
        clear_log();
        mem_lat = 8;
        wd_r = rand_line();
        drive();
        d_pmem_write = 1'b1;
        d_pmem_address = 32'h0000_0600;
        d_pmem_wdata = wd_r;
        wait_rise(1, 10, ok);
        chk("ar_start", ok, 1);
        @(posedge clk);
        #3;
        chk("ar_pre_wr", pmem_write, 1);
        rst = 1'b1;
        d_pmem_write = 1'b0;
        #1;
        chk("ar_wr", pmem_write, 0);
        chk("ar_rd", pmem_read, 0);
        chk("ar_addr", pmem_address, 0);
        chk("ar_wdata", pmem_wdata, 0);
        chk("ar_busy", arb_busy, 0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        mem_off = 1'b1;
        drive();
        pmem_resp = 1'b1;
        @(negedge clk);
        chk("stale_dresp", d_pmem_resp, 0);
        chk("stale_iresp", i_pmem_resp, 0);
        chk("stale_busy", arb_busy, 0);
        drive();
        pmem_resp = 1'b0;
        mem_off = 1'b0;
        repeat (2) drive();

        // random traffic
        clear_log();
        mem_lat = -1;
        stray_en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            drive();
            if (i_seen) begin
                i_seen = 1'b0;
                i_pmem_read = 1'b0;
            end else if (!i_pmem_read) begin
                if ($urandom_range(0, 3) == 0) begin
                    i_pmem_read = 1'b1;
                    i_pmem_address = $urandom() & 32'hFFFF_FFE0;
                end
            end else if ($urandom_range(0, 49) == 0) begin
                i_pmem_read = 1'b0;
            end else if ($urandom_range(0, 9) == 0) begin
                i_pmem_address = $urandom() & 32'hFFFF_FFE0;
            end
            if (d_seen) begin
                d_seen = 1'b0;
                d_pmem_read = 1'b0;
                d_pmem_write = 1'b0;
            end else if (!(d_pmem_read || d_pmem_write)) begin
                if ($urandom_range(0, 2) == 0) begin
                    d_pmem_write = $urandom_range(0, 1) == 1;
                    d_pmem_read = !d_pmem_write;
                    d_pmem_address = $urandom() & 32'hFFFF_FFE0;
                    d_pmem_wdata = rand_line();
                end
            end else if ($urandom_range(0, 49) == 0) begin
                d_pmem_read = 1'b0;
                d_pmem_write = 1'b0;
            end else if ($urandom_range(0, 9) == 0) begin
                d_pmem_address = $urandom() & 32'hFFFF_FFE0;
                d_pmem_wdata = rand_line();
            end
        end
        i_pmem_read = 1'b0;
        d_pmem_read = 1'b0;
        d_pmem_write = 1'b0;
        stray_en = 1'b0;
        repeat (12) drive();
        chk("rnd_traffic", (i_cnt > 20) && (d_cnt > 20), 1);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
